tp_mem_sequencer: RTL and testbench

- Shares one single-port synchronous data RAM between the TP-ISA core's two read operands and its write port.
- Sequences each instruction as read addr1, then read addr2, then execute/write-back.
- Pulses core_step for exactly one cycle per instruction; the core advances pc, flags and BAR only on that cycle.
- Sits between the core top and the data memory; also provides run/halt control and a retired-instruction counter.

---
 rtl/tp_memseq_pkg.sv | 13 +
 rtl/tp_mem_sequencer_if.sv | 14 +
 rtl/tp_mem_sequencer.sv | 141 ++++++++++++++
 tb/tb_tp_mem_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tp_memseq_pkg.sv
// Shared types and constants for the TP-ISA memory sequencer.
package tp_memseq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        EX   = 2'd3
    } memseq_state_t;

    localparam int MEMSEQ_CPI = 3;

endpackage

// File: rtl/tp_mem_sequencer_if.sv
// Single-port data RAM bus between the sequencer (master) and the RAM (slave).
interface tp_mem_sequencer_if #(
    parameter int width      = 8,
    parameter int addr_width = 8
);
    logic [addr_width-1:0] addr;
    logic                  re;
    logic                  we;
    logic [width-1:0]      wdata;
    logic [width-1:0]      rdata;

    modport master (output addr, re, we, wdata, input rdata);
    modport slave  (input addr, re, we, wdata, output rdata);
endinterface

// File: rtl/tp_mem_sequencer.sv
// Time-multiplexes one single-port RAM between the core's two reads and its write.
// Optional build macro TP_MEMSEQ_ADDR_MERGE_EN: same-address operands skip the second read.
module tp_mem_sequencer
    import tp_memseq_pkg::*;
#(
    parameter int width      = 8,
    parameter int addr_width = 8,
    parameter int cnt_width  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [addr_width-1:0] core_addr1,
    input  logic [addr_width-1:0] core_addr2,
    input  logic [width-1:0]      core_wdata,
    input  logic                  core_wen,
    output logic [width-1:0]      core_rdata1,
    output logic [width-1:0]      core_rdata2,
    output logic                  core_step,
    output logic                  halted,
    output logic [cnt_width-1:0]  retired,
    tp_mem_sequencer_if.master    mem
);

    localparam logic [cnt_width-1:0] CNT_ONE = {{(cnt_width-1){1'b0}}, 1'b1};

    memseq_state_t         state_r;
    memseq_state_t         state_s;
    logic [width-1:0]      rdata1_q;
    logic                  merged_q;
    logic [cnt_width-1:0]  retired_r;
    logic                  halted_r;

    logic [addr_width-1:0] addr_s;
    logic                  re_s;
    logic                  we_s;
    logic [width-1:0]      wdata_s;
    logic                  step_s;
    logic [width-1:0]      rdata1_s;
    logic [width-1:0]      rdata2_s;

    // Next-state and memory/core strobes, decoded from the current state
    always_comb begin
        state_s  = state_r;
        addr_s   = '0;
        re_s     = 1'b0;
        we_s     = 1'b0;
        wdata_s  = '0;
        step_s   = 1'b0;
        rdata1_s = rdata1_q;
        rdata2_s = '0;
        case (state_r)
            IDLE: begin
                if (run) begin
                    state_s = RD1;
                end else begin
                    state_s = IDLE;
                end
            end
            RD1: begin
                re_s   = 1'b1;
                addr_s = core_addr1;
`ifdef TP_MEMSEQ_ADDR_MERGE_EN
                if (core_addr1 == core_addr2) begin
                    state_s = EX;
                end else begin
                    state_s = RD2;
                end
`else
                state_s = RD2;
`endif
            end
            RD2: begin
                re_s    = 1'b1;
                addr_s  = core_addr2;
                state_s = EX;
            end
            EX: begin
                step_s   = 1'b1;
                we_s     = core_wen;
                addr_s   = core_addr1;
                wdata_s  = core_wdata;
                rdata2_s = mem.rdata;
                // A merged instruction never latched operand 1; the live read serves both
                if (merged_q) begin
                    rdata1_s = mem.rdata;
                end else begin
                    rdata1_s = rdata1_q;
                end
                if (run) begin
                    state_s = RD1;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register, operand-1 latch, merge flag, retired counter and halted flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            rdata1_q  <= '0;
            merged_q  <= 1'b0;
            retired_r <= '0;
            halted_r  <= 1'b1;
        end else begin
            state_r  <= state_s;
            halted_r <= (state_s == IDLE);
            if (state_r == RD2) begin
                rdata1_q <= mem.rdata;
            end
            if (state_r == EX) begin
                retired_r <= retired_r + CNT_ONE;
            end
`ifdef TP_MEMSEQ_ADDR_MERGE_EN
            if (state_r == RD1) begin
                merged_q <= (core_addr1 == core_addr2);
            end else if (state_r == EX) begin
                merged_q <= 1'b0;
            end
`else
            merged_q <= 1'b0;
`endif
        end
    end

    assign mem.addr    = addr_s;
    assign mem.re      = re_s;
    assign mem.we      = we_s;
    assign mem.wdata   = wdata_s;
    assign core_step   = step_s;
    assign core_rdata1 = rdata1_s;
    assign core_rdata2 = rdata2_s;
    assign retired     = retired_r;
    assign halted      = halted_r;

endmodule

// File: tb/tb_tp_mem_sequencer.sv
// Randomized bench for tp_mem_sequencer against an instruction-level model of the RAM and counter.
module tb_tp_mem_sequencer;
    import tp_memseq_pkg::*;

    localparam int W  = 8;
    localparam int AW = 8;
    localparam int CW = 4;
`ifdef TP_MEMSEQ_ADDR_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic [AW-1:0] core_addr1, core_addr2;
    logic [W-1:0]  core_wdata;
    logic          core_wen;
    logic [W-1:0]  core_rdata1, core_rdata2;
    logic          core_step, halted;
    logic [CW-1:0] retired;

    tp_mem_sequencer_if #(.width(W), .addr_width(AW)) mem_if ();

    tp_mem_sequencer #(.width(W), .addr_width(AW), .cnt_width(CW)) dut (
        .clk(clk), .reset(reset), .run(run),
        .core_addr1(core_addr1), .core_addr2(core_addr2),
        .core_wdata(core_wdata), .core_wen(core_wen),
        .core_rdata1(core_rdata1), .core_rdata2(core_rdata2),
        .core_step(core_step), .halted(halted), .retired(retired),
        .mem(mem_if)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: registered read held until the next read, plus a preload port
    logic [W-1:0]  ram [0:255];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr;
    logic [W-1:0]  pl_data;
    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_if.we) ram[mem_if.addr] <= mem_if.wdata;
        if (mem_if.re) mem_if.rdata <= ram[mem_if.addr];
    end

    logic [W-1:0] refmem [0:255];
    int ref_retired = 0;
    int checks = 0;
    int errors = 0;
    bit idle;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction from the current cycle (IDLE or RD1) through the cycle after its step
    task automatic do_instr(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                            input logic [W-1:0] wd, input logic wen,
                            input bit from_idle, input bit keep_run);
        int exp_c;
        int c;
        logic [W-1:0] e1, e2;
        core_addr1 = a1; core_addr2 = a2; core_wdata = wd; core_wen = wen; run = 1'b1;
        #1;
        e1 = refmem[a1];
        e2 = refmem[a2];
        exp_c = ((MERGE && (a1 == a2)) ? 2 : MEMSEQ_CPI) + (from_idle ? 1 : 0);
        c = 1;
        while (core_step !== 1'b1 && c < 12) begin
            check("re_we_exclusive", 32'(mem_if.re & mem_if.we), 32'd0);
            tick();
            c++;
        end
        check("step_latency", 32'(c), 32'(exp_c));
        check("ex_rdata1", 32'(core_rdata1), 32'(e1));
        check("ex_rdata2", 32'(core_rdata2), 32'(e2));
        check("ex_we", 32'(mem_if.we), 32'(wen));
        check("ex_re", 32'(mem_if.re), 32'd0);
        check("ex_addr", 32'(mem_if.addr), 32'(a1));
        if (wen) check("ex_wdata", 32'(mem_if.wdata), 32'(wd));
        check("retired_in_ex", 32'(retired), 32'(ref_retired));
        if (wen) refmem[a1] = wd;
        ref_retired = (ref_retired + 1) % (1 << CW);
        if (!keep_run) run = 1'b0;
        tick();
        check("step_single", 32'(core_step), 32'd0);
        check("retired_after", 32'(retired), 32'(ref_retired));
        check("halted_after", 32'(halted), 32'(!keep_run));
        idle = !keep_run;
    endtask

    initial begin
        int nmis;
        logic [AW-1:0] a1, a2;
        logic [W-1:0] d;
        reset = 1'b1; run = 1'b0;
        core_addr1 = 8'h00; core_addr2 = 8'h00; core_wdata = 8'h00; core_wen = 1'b0;
        #2;
        check("rst_step", 32'(core_step), 32'd0);
        check("rst_re", 32'(mem_if.re), 32'd0);
        check("rst_we", 32'(mem_if.we), 32'd0);
        check("rst_addr", 32'(mem_if.addr), 32'd0);
        check("rst_wdata", 32'(mem_if.wdata), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_halted", 32'(halted), 32'd1);
        check("rst_rdata1", 32'(core_rdata1), 32'd0);
        check("rst_rdata2", 32'(core_rdata2), 32'd0);

        for (int i = 0; i < 256; i++) begin
            d = W'($urandom);
            if (i == 8'h10) d = 8'h05;
            if (i == 8'h20) d = 8'h03;
            if (i == 8'h30) d = 8'h7F;
            pl_en = 1'b1; pl_addr = AW'(i); pl_data = d;
            refmem[i] = d;
            tick();
        end
        pl_en = 1'b0;
        reset = 1'b0;
        tick();
        check("idle_halted", 32'(halted), 32'd1);
        idle = 1'b1;

        do_instr(8'h10, 8'h20, 8'h08, 1'b1, idle, 1'b0);
        check("ram_10_written", 32'(ram[8'h10]), 32'h08);
        check("retired_one", 32'(retired), 32'd1);

        for (int i = 0; i < 10; i++)
            do_instr(AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                     W'($urandom), 1'($urandom), idle, i != 9);
        check("retired_eleven", 32'(retired), 32'd11);

        // run drops while the second operand is being read
        core_addr1 = 8'h21; core_addr2 = 8'h22; core_wdata = 8'hA5; core_wen = 1'b1; run = 1'b1;
        tick();
        tick();
        run = 1'b0;
        tick();
        check("rd2drop_step", 32'(core_step), 32'd1);
        check("rd2drop_rdata2", 32'(core_rdata2), 32'(refmem[8'h22]));
        refmem[8'h21] = 8'hA5;
        ref_retired = (ref_retired + 1) % (1 << CW);
        tick();
        check("rd2drop_halted", 32'(halted), 32'd1);
        nmis = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_if.re !== 1'b0 || core_step !== 1'b0) nmis++;
            tick();
        end
        check("rd2drop_quiet", 32'(nmis), 32'd0);
        check("rd2drop_retired", 32'(retired), 32'(ref_retired));

        do_instr(8'h30, 8'h30, 8'h00, 1'b0, idle, 1'b1);
        do_instr(8'h30, 8'h31, 8'h00, 1'b0, idle, 1'b0);

        // reset asserted in EX with a write pending
        d = ~refmem[8'h40];
        core_addr1 = 8'h40; core_addr2 = 8'h41; core_wdata = d; core_wen = 1'b1; run = 1'b1;
        tick();
        tick();
        tick();
        check("rstex_in_ex", 32'(core_step), 32'd1);
        check("rstex_we_before", 32'(mem_if.we), 32'd1);
        reset = 1'b1;
        run = 1'b0;
        #1;
        check("rstex_we", 32'(mem_if.we), 32'd0);
        check("rstex_step", 32'(core_step), 32'd0);
        check("rstex_re", 32'(mem_if.re), 32'd0);
        check("rstex_addr", 32'(mem_if.addr), 32'd0);
        check("rstex_wdata", 32'(mem_if.wdata), 32'd0);
        check("rstex_retired", 32'(retired), 32'd0);
        check("rstex_halted", 32'(halted), 32'd1);
        check("rstex_rdata1", 32'(core_rdata1), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("rstex_ram_kept", 32'(ram[8'h40]), 32'(refmem[8'h40]));
        ref_retired = 0;
        idle = 1'b1;

        for (int i = 0; i < 17; i++)
            do_instr(AW'($urandom_range(8'h50, 8'h57)), AW'($urandom_range(8'h50, 8'h57)),
                     W'($urandom), 1'($urandom), idle, i != 16);
        check("wrap_end", 32'(retired), 32'd1);

        for (int i = 0; i < 40; i++) begin
            a1 = AW'($urandom_range(8'h30, 8'h37));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : AW'($urandom_range(8'h30, 8'h37));
            do_instr(a1, a2, W'($urandom), 1'($urandom), idle, $urandom_range(0, 3) != 0);
        end

        nmis = 0;
        for (int i = 0; i < 256; i++)
            if (ram[i] !== refmem[i]) nmis++;
        check("ram_final", 32'(nmis), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
